// File: rtl/rf_access_ctrl_if.sv
// rf_access_ctrl_if: byte-stream, register-file and transmit signals of the command controller
interface rf_access_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] Rx_Data;
  logic                  Rx_Valid;
  logic [DATA_WIDTH-1:0] WrData;
  logic [ADDR_WIDTH-1:0] Address;
  logic                  WrEn;
  logic                  RdEn;
  logic [DATA_WIDTH-1:0] RdData;
  logic [DATA_WIDTH-1:0] Tx_Data;
  logic                  Tx_Valid;
  logic                  Tx_Busy;
  logic                  Ctrl_Busy;
  modport master (
    input  Rx_Data, Rx_Valid, RdData, Tx_Busy,
    output WrData, Address, WrEn, RdEn, Tx_Data, Tx_Valid, Ctrl_Busy
  );
  modport slave (
    output Rx_Data, Rx_Valid, RdData, Tx_Busy,
    input  WrData, Address, WrEn, RdEn, Tx_Data, Tx_Valid, Ctrl_Busy
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: turns framed command bytes into register-file write/read strobes and sends read data to TX
module rf_access_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB
) (
  input  logic          CLK,
  input  logic          RST,
  rf_access_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_STROBE, RD_CAPTURE, TX_WAIT} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d, txdata_q, txdata_d, cap_q, cap_d;
  logic                  wren_q, wren_d, rden_q, rden_d, txvalid_q, txvalid_d;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      txdata_q  <= '0;
      cap_q     <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      txvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      txdata_q  <= txdata_d;
      cap_q     <= cap_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      txvalid_q <= txvalid_d;
    end
  // WR_DATA is left only in the WrEn cycle, so a byte arriving alongside WrEn is dropped
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    txdata_d  = txdata_q;
    cap_d     = cap_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    txvalid_d = 1'b0;
    case (state_q)
      IDLE:
        if (bus.Rx_Valid)
          state_d = bus.Rx_Data == WR_CMD ? WR_ADDR : bus.Rx_Data == RD_CMD ? RD_ADDR : IDLE;
      WR_ADDR:
        if (bus.Rx_Valid) begin
          addr_d  = bus.Rx_Data[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      WR_DATA:
        if (wren_q) state_d = IDLE;
        else if (bus.Rx_Valid) begin
          wrdata_d = bus.Rx_Data;
          wren_d   = 1'b1;
        end
      RD_ADDR:
        if (bus.Rx_Valid) begin
          addr_d  = bus.Rx_Data[ADDR_WIDTH-1:0];
          rden_d  = 1'b1;
          state_d = RD_STROBE;
        end
      RD_STROBE: state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        cap_d   = bus.RdData;
        state_d = TX_WAIT;
      end
      TX_WAIT:
        if (!bus.Tx_Busy) begin
          txdata_d  = cap_q;
          txvalid_d = 1'b1;
          state_d   = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  assign bus.WrData    = wrdata_q;
  assign bus.Address   = addr_q;
  assign bus.WrEn      = wren_q;
  assign bus.RdEn      = rden_q;
  assign bus.Tx_Data   = txdata_q;
  assign bus.Tx_Valid  = txvalid_q;
  assign bus.Ctrl_Busy = state_q != IDLE;
endmodule
